// File: rtl/audio_clk_nco.sv
// Multi-channel NCO clock-enable generator. Ticks and square waves run only after PLL lock settles.
// Optional macro NCO_PHASE_ALIGN_EN adds sync_in, which zeroes all accumulators while in RUN.
module audio_clk_nco #(
    parameter int unsigned      NUM_CH        = 2,
    parameter int unsigned      ACC_W         = 32,
    parameter int unsigned      SETTLE_CYCLES = 1024,
    parameter logic [ACC_W-1:0] INC_RESET     = '0
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
`ifdef NCO_PHASE_ALIGN_EN
    input  logic              sync_in,
`endif
    input  logic              inc_wr,
    input  logic [2:0]        inc_ch,
    input  logic [ACC_W-1:0]  inc_data,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic              ready
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StSettle, StRun} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;

    logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0][ACC_W-1:0] inc_q, inc_d;
    logic [NUM_CH-1:0][ACC_W-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0]            pend_vld_q, pend_vld_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic [NUM_CH-1:0]            clk_q, clk_d;
    logic [NUM_CH-1:0]            carry;
    logic [ACC_W:0]               sum;

    logic run, advance, clear, wr_valid;

    // Lock FSM; the counter holds the number of consecutive locked cycles seen so far.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pll_locked) begin
                    cnt_d   = CNT_W'(1);
                    state_d = (SETTLE_CYCLES <= 1) ? StRun : StSettle;
                end
            end
            StSettle: begin
                if (!pll_locked) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRun: begin
                if (!pll_locked) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == StRun);
    end

    assign run      = (state_q == StRun);
    assign wr_valid = inc_wr && ({29'b0, inc_ch} < NUM_CH);

`ifdef NCO_PHASE_ALIGN_EN
    assign clear   = run && (!pll_locked || sync_in);
    assign advance = run && pll_locked && !sync_in;
`else
    assign clear   = run && !pll_locked;
    assign advance = run && pll_locked;
`endif

    always_comb begin
        acc_d      = acc_q;
        inc_d      = inc_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        tick_d     = '0;
        clk_d      = clk_q;
        carry      = '0;
        sum        = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (clear) begin
                acc_d[c] = '0;
                clk_d[c] = 1'b0;
            end else if (advance) begin
                sum       = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
                acc_d[c]  = sum[ACC_W-1:0];
                carry[c]  = sum[ACC_W];
                tick_d[c] = sum[ACC_W];
                clk_d[c]  = sum[ACC_W-1];
            end
            // A running channel only swaps increments at its carry edge, keeping periods whole.
            if (wr_valid && ({29'b0, inc_ch} == c)) begin
                if (!run || (inc_q[c] == '0) || carry[c]) begin
                    inc_d[c]      = inc_data;
                    pend_vld_d[c] = 1'b0;
                end else begin
                    pend_d[c]     = inc_data;
                    pend_vld_d[c] = 1'b1;
                end
            end else if (carry[c] && pend_vld_q[c]) begin
                inc_d[c]      = pend_q[c];
                pend_vld_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            acc_q      <= '0;
            inc_q      <= {NUM_CH{INC_RESET}};
            pend_q     <= '0;
            pend_vld_q <= '0;
            tick_q     <= '0;
            clk_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            tick_q     <= tick_d;
            clk_q      <= clk_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_audio_clk_nco.sv
// Self-checking bench for audio_clk_nco: per-cycle model compare plus directed literal checks.
module tb_audio_clk_nco;

    localparam int unsigned NCH = 2;
    localparam int unsigned AW  = 8;
    localparam int unsigned SC  = 16;
    localparam int unsigned MOD = 256;

    logic           refclk     = 1'b0;
    logic           rst_n      = 1'b0;
    logic           pll_locked = 1'b0;
    logic           inc_wr     = 1'b0;
    logic [2:0]     inc_ch     = '0;
    logic [AW-1:0]  inc_data   = '0;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
    logic           ready;
`ifdef NCO_PHASE_ALIGN_EN
    logic           sync_in    = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 refclk = ~refclk;

    audio_clk_nco #(
        .NUM_CH        (NCH),
        .ACC_W         (AW),
        .SETTLE_CYCLES (SC),
        .INC_RESET     (8'd0)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
`ifdef NCO_PHASE_ALIGN_EN
        .sync_in    (sync_in),
`endif
        .inc_wr     (inc_wr),
        .inc_ch     (inc_ch),
        .inc_data   (inc_data),
        .tick       (tick),
        .clk_out    (clk_out),
        .ready      (ready)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ready follows SC consecutive locked samples; each channel is an integer phase mod 2^AW.
    int unsigned    m_streak;
    bit             m_ready;
    bit             m_run_now;
    bit             m_wrap;
    int unsigned    m_sum;
    int unsigned    m_phase [NCH];
    int unsigned    m_inc   [NCH];
    int unsigned    m_pend  [NCH];
    bit             m_pv    [NCH];
    bit [NCH-1:0]   m_tick;
    bit [NCH-1:0]   m_clk;

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            m_streak = 0;
            m_ready  = 1'b0;
            m_tick   = '0;
            m_clk    = '0;
            for (int c = 0; c < NCH; c++) begin
                m_phase[c] = 0;
                m_inc[c]   = 0;
                m_pend[c]  = 0;
                m_pv[c]    = 1'b0;
            end
        end else begin
            m_run_now = (m_streak >= SC);
            for (int c = 0; c < NCH; c++) begin
                m_wrap = 1'b0;
                if (m_run_now && pll_locked) begin
                    m_sum      = m_phase[c] + m_inc[c];
                    m_wrap     = (m_sum >= MOD);
                    m_phase[c] = m_sum % MOD;
                    m_tick[c]  = m_wrap;
                    m_clk[c]   = (m_phase[c] >= MOD / 2);
                end else if (m_run_now) begin
                    m_phase[c] = 0;
                    m_tick[c]  = 1'b0;
                    m_clk[c]   = 1'b0;
                end else begin
                    m_tick[c] = 1'b0;
                end
                if (inc_wr && int'(inc_ch) == c) begin
                    if (!m_run_now || m_inc[c] == 0 || m_wrap) begin
                        m_inc[c] = int'(inc_data);
                        m_pv[c]  = 1'b0;
                    end else begin
                        m_pend[c] = int'(inc_data);
                        m_pv[c]   = 1'b1;
                    end
                end else if (m_wrap && m_pv[c]) begin
                    m_inc[c] = m_pend[c];
                    m_pv[c]  = 1'b0;
                end
            end
            if (!pll_locked) m_streak = 0;
            else if (m_streak < SC) m_streak = m_streak + 1;
            m_ready = (m_streak >= SC);
        end
    end

    always @(negedge refclk) begin
        if (rst_n) begin
            check("model_ready", int'(ready), int'(m_ready));
            check("model_tick", int'(tick), int'(m_tick));
            check("model_clk_out", int'(clk_out), int'(m_clk));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic wr_inc(input int ch, input int data);
        inc_wr   = 1'b1;
        inc_ch   = ch[2:0];
        inc_data = data[AW-1:0];
        cyc(1);
        inc_wr   = 1'b0;
    endtask

    // Cycles until tick[0] is next seen high; 64 means the bound expired.
    task automatic next_tick0(output int gap);
        gap = 0;
        do begin
            cyc(1);
            gap++;
        end while (!tick[0] && gap < 64);
    endtask

    int exp_clk0  [9] = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
    int exp_tick0 [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    int exp_clk1  [9] = '{0, 0, 1, 0, 1, 1, 0, 1, 0};
    int exp_tick1 [9] = '{0, 0, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        int cnt0;
        int cnt1;
        int g;

        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        check("reset_ready", int'(ready), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_clk_out", int'(clk_out), 0);

        // Increments written before lock load directly.
        wr_inc(0, 64);
        wr_inc(1, 96);
        cyc(2);

        pll_locked = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            check("settle_ready", int'(ready), (k >= 16) ? 1 : 0);
            if (k < 16) begin
                check("pre_ready_tick", int'(tick), 0);
                check("pre_ready_clk_out", int'(clk_out), 0);
            end else begin
                check("ch0_clk_out", int'(clk_out[0]), exp_clk0[k-16]);
                check("ch0_tick", int'(tick[0]), exp_tick0[k-16]);
                check("ch1_clk_out", int'(clk_out[1]), exp_clk1[k-16]);
                check("ch1_tick", int'(tick[1]), exp_tick1[k-16]);
            end
            cyc(1);
        end

        cnt0 = 0;
        cnt1 = 0;
        repeat (800) begin
            cyc(1);
            cnt0 += int'(tick[0]);
            cnt1 += int'(tick[1]);
        end
        check("ch0_ticks_800", cnt0, 200);
        check("ch1_ticks_800", cnt1, 300);

        // Rate change mid-period: current period completes, then the new one applies.
        next_tick0(g);
        cyc(1);
        wr_inc(0, 32);
        next_tick0(g);
        check("rate_change_gap_old", g, 2);
        next_tick0(g);
        check("rate_change_gap_new", g, 8);
        next_tick0(g);
        check("rate_change_gap_new2", g, 8);
        cnt1 = 0;
        repeat (16) begin
            cyc(1);
            cnt1 += int'(tick[1]);
        end
        check("ch1_ticks_16", cnt1, 6);

        // One-cycle lock drop during RUN.
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
        check("drop_tick", int'(tick), 0);
        check("drop_clk_out", int'(clk_out), 0);
        for (int k = 1; k <= 17; k++) begin
            check("relock_ready", int'(ready), (k == 17) ? 1 : 0);
            if (k < 17) check("relock_tick", int'(tick), 0);
            cyc(1);
        end
        next_tick0(g);
        check("relock_first_gap", g, 7);

        // Out-of-range channel write is ignored.
        wr_inc(5, 8);
        next_tick0(g);
        next_tick0(g);
        check("bad_ch_gap0", g, 8);
        next_tick0(g);
        check("bad_ch_gap1", g, 8);
        cnt1 = 0;
        repeat (16) begin
            cyc(1);
            cnt1 += int'(tick[1]);
        end
        check("bad_ch_ch1_ticks", cnt1, 6);

        // Asynchronous reset while clk_out[0] is high in RUN.
        g = 0;
        while (!clk_out[0] && g < 32) begin
            cyc(1);
            g++;
        end
        check("run_clk_high_seen", int'(clk_out[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_clk_out", int'(clk_out), 0);
        check("async_rst_ready", int'(ready), 0);
        rst_n = 1'b1;
        cyc(1);

        // Reset mid-SETTLE: FSM restarts from IDLE.
        pll_locked = 1'b0;
        cyc(2);
        pll_locked = 1'b1;
        cyc(6);
        #2 rst_n = 1'b0;
        #1;
        check("settle_rst_ready", int'(ready), 0);
        check("settle_rst_tick", int'(tick), 0);
        check("settle_rst_clk_out", int'(clk_out), 0);
        rst_n = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            check("post_rst_ready", int'(ready), (k == 16) ? 1 : 0);
            cyc(1);
        end
        // Increments return to zero after reset, so channels stay frozen.
        cyc(10);
        check("post_rst_tick", int'(tick), 0);
        check("post_rst_clk_out", int'(clk_out), 0);
        check("post_rst_ready_hold", int'(ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_clk_nco.md
Name: audio_clk_nco

Overview:
- Multi-channel numerically-controlled clock-enable generator.
- Runs on a PLL output clock and derives audio-rate ticks (sample, bit and MIDI rates) plus divided square-wave clocks.
- Each channel has a runtime-programmable fractional increment, updated glitch-free at wrap.
- Gates all outputs on an upstream PLL lock with a settle period; exports a combined ready flag to the audio datapath.

Parameters:
- NUM_CH, 2, number of independent NCO channels (1..8).
- ACC_W, 32, phase accumulator and increment width in bits (8..32).
- SETTLE_CYCLES, 1024, refclk cycles pll_locked must stay high before ready asserts (>=1).
- INC_RESET, 0, increment loaded into every channel at reset.

Ports:
- refclk  in  1  block clock (PLL output clock).
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  lock indication from PLL; already synchronous to refclk.
- inc_wr  in  1  increment write strobe, single-cycle.
- inc_ch  in  3  target channel index for inc_wr.
- inc_data  in  ACC_W  new increment value.
- tick  out  NUM_CH  per-channel one-cycle pulse on accumulator wrap.
- clk_out  out  NUM_CH  per-channel registered accumulator MSB (≈50% square wave).
- ready  out  1  high while in RUN.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, all accumulators=0, active increments=INC_RESET, pending flags=0, tick=0, clk_out=0, ready=0.
- Lock FSM:
  - IDLE: settle counter=0. pll_locked=1 -> SETTLE.
  - SETTLE: counter increments each cycle. pll_locked=0 -> IDLE. Counter reaching SETTLE_CYCLES-1 -> RUN.
  - RUN: ready=1 (registered; first high cycle is the first RUN cycle). pll_locked=0 -> IDLE.
- Leaving RUN for IDLE, on the same edge: clear all accumulators, tick and clk_out to 0. Active and pending increments are kept.
- Accumulators advance only in RUN: acc <= (acc + inc_active) mod 2^ACC_W.
- tick[c] is registered. It is high exactly the cycle after an add that carried out of bit ACC_W-1, i.e. aligned with the wrapped accumulator value.
- clk_out[c] = acc[c][ACC_W-1], registered with the accumulator.
- inc_active=0 freezes the channel: no ticks, clk_out holds its value.
- Increment update when inc_wr=1 and inc_ch<NUM_CH:
  - Channel not in RUN, or its inc_active==0: inc_data loads directly into inc_active on that edge.
  - Otherwise: inc_data is stored as pending and pending flag is set. On that channel's next carry edge, pending -> inc_active and the flag clears.
  - A new write while pending overwrites the pending value (last write wins).
  - Write on the same edge as a carry: inc_data is applied directly at that carry; pending flag clears.
- inc_wr with inc_ch>=NUM_CH is ignored with no side effects.
- Increment updates never alter the accumulator value, so there is no phase jump.
- Channels are fully independent; simultaneous carries on several channels are legal.
- Output frequency = f_refclk * inc / 2^ACC_W.

Optional Feature:
- Macro NCO_PHASE_ALIGN_EN.
- Defined: adds input port sync_in (1 bit).
  - sync_in=1 in RUN clears all accumulators to 0 on that edge; tick and clk_out are 0 in the following cycle.
  - sync_in has priority over normal accumulation and carry. Pending increments stay pending.
  - sync_in is ignored outside RUN.
- Not defined: port absent; accumulators are never cleared except by reset or loss of lock.

Test Plan:
- ACC_W=8, SETTLE_CYCLES=16; pll_locked rises at cycle 0 -> ready=0 through cycle 15, ready=1 from cycle 16; tick/clk_out stay 0 before ready.
- ACC_W=8, inc=64 on ch0, RUN -> acc sequence 64,128,192,0. tick[0] high every 4th cycle, one cycle wide. clk_out[0] pattern 0,1,1,0 repeating.
- ACC_W=8, inc=96 -> exactly 3 ticks per 8 cycles (fractional spacing 3,3,2). Over 800 cycles, count=300.
- ch0 running inc=64, write inc_data=32 mid-period -> period stays 4 until the next wrap, then becomes 8. Ticks on ch1 unaffected.
- pll_locked dropped for 1 cycle during RUN -> ready=0 next cycle, accumulators=0, no ticks. ready reasserts exactly 16 cycles after lock returns.
- inc_ch=5 with NUM_CH=2 -> no channel changes. Additionally, rst_n asserted mid-SETTLE -> all outputs 0 immediately, FSM in IDLE.
